device_req_bridge: RTL and testbench
====================================

# device_req_bridge

Upstream front-end for the simulation MMIO device helper. Accepts 64-bit MMIO requests on a valid/ready channel and splits each one into at most two 32-bit single-cycle helper beats. It issues a beat only for a word half that carries enabled bytes. It captures each beat's read data one cycle later and returns a 64-bit response on a valid/ready channel. It sits between the SoC-side MMIO port of the difftest/simulation top and the DPI device helper.

## Interface
- `ADDR_LO`, default `32'h4000_0000`: inclusive lower bound of the legal device window (range check only).
- `ADDR_HI`, default `32'h8000_0000`: exclusive upper bound of the legal device window (range check only).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request ready; high only in IDLE.
- `req_wen`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_size`  in  2  read size: 0/1/2/3 = 1/2/4/8 bytes. Ignored for writes.
- `req_wdata`  in  64  write data.
- `req_wmask`  in  8  byte write mask.
- `dev_req_valid`  out  1  helper beat strobe; exactly one cycle per beat.
- `dev_req_wen`  out  1  beat write enable.
- `dev_req_addr`  out  32  beat word address.
- `dev_req_wdata`  out  32  beat write data.
- `dev_req_wmask`  out  4  beat byte mask; 0 for reads.
- `dev_resp_rdata`  in  32  helper read data; valid in the cycle after the beat.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response ready.
- `resp_rdata`  out  64  read data; 0 for writes.
- `resp_err`  out  1  out-of-range error flag.

## Operation
- Accept: a request is accepted when `req_valid && req_ready`. On accept, latch wen, addr, size, wdata, wmask and compute the beat plan.
  - Base address = `{req_addr[31:3],3'b000}`.
  - Low beat uses the base address. High beat uses base + 4.
- Beat plan for writes:
  - Issue the low beat iff `wmask[3:0]!=0`.
  - Issue the high beat iff `wmask[7:4]!=0`.
- Beat plan for reads:
  - `size==3` issues both beats.
  - `size<3` issues only the beat selected by `addr[2]`. Bytes that would cross into the other word are dropped.
- Beat contents: the low beat carries `wdata[31:0]` and `wmask[3:0]`. The high beat carries `wdata[63:32]` and `wmask[7:4]`.
- States: IDLE, BEAT_LO, BEAT_HI, FIN, RESP.
  - IDLE to BEAT_LO if the low beat is planned. Otherwise to BEAT_HI if the high beat is planned. Otherwise to RESP (zero-beat request).
  - BEAT_LO drives `dev_req_valid=1`. Next state is BEAT_HI if the high beat is planned, else FIN.
  - BEAT_HI drives `dev_req_valid=1`. If the previous state was BEAT_LO, capture `dev_resp_rdata` into `rdata[31:0]`. Next state is FIN.
  - FIN: no beat. Capture `dev_resp_rdata` into the half of the last beat issued. Next state is RESP.
  - RESP: `resp_valid=1` with outputs held stable. Next state is IDLE on `resp_ready`.
- Read data:
  - Halves not issued read as 0.
  - The captured half is always the full 32-bit word; there is no byte shifting.
  - Writes never capture, so `resp_rdata=0`.
- Idle helper outputs: when `dev_req_valid=0`, all `dev_req_*` outputs are 0.
- A new request is never accepted in the same cycle a response completes. IDLE is always entered first.

## Timing
- Reset values: `req_ready=0` while `reset_n` is low, and 1 in IDLE after release. All other outputs are 0. State is IDLE.
- Reset mid-transaction: asynchronous reset drops the transaction immediately. No further beats are issued and no response is produced.
- Latency from the accept cycle (cycle 0) to the first `resp_valid` cycle:
  - Two beats: 4 cycles.
  - One beat: 3 cycles.
  - Zero beats or range error: 1 cycle.
- Back-to-back beats: the two beats occupy consecutive cycles (BEAT_LO at cycle 1, BEAT_HI at cycle 2).
- Backpressure: `resp_valid` stays high, with stable `resp_rdata`/`resp_err`, until `resp_ready` is seen. Minimum occupancy is one cycle in RESP.
- Throughput: at most one request in flight.

## Configuration
- Macro: `DEVICE_BRIDGE_RANGE_CHECK_EN`.
- When defined:
  - An accepted request with `req_addr<ADDR_LO` or `req_addr>=ADDR_HI` issues no beats.
  - It goes IDLE to RESP with `resp_err=1` and `resp_rdata=0`.
  - Legal requests return `resp_err=0`.
- When not defined: there is no range check and `resp_err` is tied to 0.

## Test plan
- 8-byte read at `0x4060_0000`, with helper returning `0x1111_1111` then `0x2222_2222`:
  - Beats at `0x4060_0000` and `0x4060_0004` in consecutive cycles.
  - `resp_rdata=0x2222_2222_1111_1111`, `resp_valid` 4 cycles after accept.
- Write `addr=0x4060_0004`, `wmask=0xF0`, `wdata=0xAABBCCDD_00000000`:
  - Single beat at `0x4060_0004` with `dev_req_wdata=0xAABBCCDD` and `dev_req_wmask=0xF`.
  - Response after 3 cycles, `resp_rdata=0`.
- Write with `wmask=0x00`: no `dev_req_valid`; `resp_valid` 1 cycle after accept.
- Response backpressure: hold `resp_ready=0` for 5 cycles.
  - `resp_valid`/`resp_rdata` are stable and `req_ready=0` throughout.
  - Accept resumes one cycle after the handshake.
- Assert `reset_n` low during BEAT_HI: all outputs 0 immediately; after release, IDLE with `req_ready=1` and no stale response.
- With `DEVICE_BRIDGE_RANGE_CHECK_EN`, read at `0x8000_0000`: no beats; `resp_err=1` and `resp_rdata=0` 1 cycle after accept.

Source files
------------

// File: rtl/device_req_bridge.sv
// ============================================================================
// Module      : device_req_bridge
// Description : Splits 64-bit MMIO requests into up to two 32-bit helper beats
//               and returns a 64-bit response. Optional address window check
//               enabled by the DEVICE_BRIDGE_RANGE_CHECK_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module device_req_bridge #(
  parameter logic [31:0] ADDR_LO = 32'h4000_0000,
  parameter logic [31:0] ADDR_HI = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        dev_req_valid,
  output logic        dev_req_wen,
  output logic [31:0] dev_req_addr,
  output logic [31:0] dev_req_wdata,
  output logic [3:0]  dev_req_wmask,
  input  logic [31:0] dev_resp_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_BEAT_LO = 3'd1;
  localparam logic [2:0] S_BEAT_HI = 3'd2;
  localparam logic [2:0] S_FIN     = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic        r_wen;
  logic [28:0] r_base;
  logic [63:0] r_wdata;
  logic [7:0]  r_wmask;
  logic        r_plan_lo;
  logic        r_plan_hi;
  logic        r_err;
  logic [63:0] r_rdata;

  logic        w_accept;
  logic        w_out_of_range;
  logic        w_err;
  logic        w_plan_lo;
  logic        w_plan_hi;

  assign w_accept       = req_valid && (r_state == S_IDLE);
  assign w_out_of_range = (req_addr < ADDR_LO) || (req_addr >= ADDR_HI);

`ifdef DEVICE_BRIDGE_RANGE_CHECK_EN
  assign w_err = w_out_of_range;
`else
  logic w_unused;
  assign w_unused = w_out_of_range;
  assign w_err    = 1'b0;
`endif

  // Reads narrower than 8 bytes touch only the word selected by addr[2].
  always_comb begin
    w_plan_lo = 1'b0;
    w_plan_hi = 1'b0;
    if (!w_err) begin
      if (req_wen) begin
        w_plan_lo = |req_wmask[3:0];
        w_plan_hi = |req_wmask[7:4];
      end else if (req_size == 2'd3) begin
        w_plan_lo = 1'b1;
        w_plan_hi = 1'b1;
      end else begin
        w_plan_lo = !req_addr[2];
        w_plan_hi = req_addr[2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_plan_lo)      w_next_state = S_BEAT_LO;
          else if (w_plan_hi) w_next_state = S_BEAT_HI;
          else                w_next_state = S_RESP;
        end
      end
      S_BEAT_LO: w_next_state = r_plan_hi ? S_BEAT_HI : S_FIN;
      S_BEAT_HI: w_next_state = S_FIN;
      S_FIN:     w_next_state = S_RESP;
      S_RESP:    w_next_state = resp_ready ? S_IDLE : S_RESP;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Helper read data lags its beat by one cycle, so BEAT_HI collects the low
  // word and FIN collects whichever word was issued last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wen     <= 1'b0;
      r_base    <= '0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_plan_lo <= 1'b0;
      r_plan_hi <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else if (w_accept) begin
      r_wen     <= req_wen;
      r_base    <= req_addr[31:3];
      r_wdata   <= req_wdata;
      r_wmask   <= req_wmask;
      r_plan_lo <= w_plan_lo;
      r_plan_hi <= w_plan_hi;
      r_err     <= w_err;
      r_rdata   <= '0;
    end else if (!r_wen) begin
      if (r_state == S_BEAT_HI && r_plan_lo) begin
        r_rdata[31:0] <= dev_resp_rdata;
      end else if (r_state == S_FIN) begin
        if (r_plan_hi) r_rdata[63:32] <= dev_resp_rdata;
        else           r_rdata[31:0]  <= dev_resp_rdata;
      end
    end
  end

  always_comb begin
    req_ready     = 1'b0;
    dev_req_valid = 1'b0;
    dev_req_wen   = 1'b0;
    dev_req_addr  = '0;
    dev_req_wdata = '0;
    dev_req_wmask = '0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_err      = 1'b0;
    case (r_state)
      S_IDLE: req_ready = reset_n;
      S_BEAT_LO: begin
        dev_req_valid = 1'b1;
        dev_req_wen   = r_wen;
        dev_req_addr  = {r_base, 3'b000};
        dev_req_wdata = r_wen ? r_wdata[31:0] : 32'd0;
        dev_req_wmask = r_wen ? r_wmask[3:0] : 4'd0;
      end
      S_BEAT_HI: begin
        dev_req_valid = 1'b1;
        dev_req_wen   = r_wen;
        dev_req_addr  = {r_base, 3'b100};
        dev_req_wdata = r_wen ? r_wdata[63:32] : 32'd0;
        dev_req_wmask = r_wen ? r_wmask[7:4] : 4'd0;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = r_rdata;
        resp_err   = r_err;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_device_req_bridge.sv
// ============================================================================
// Module      : tb_device_req_bridge
// Description : Directed self-checking bench for device_req_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_device_req_bridge;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        dev_req_valid;
  logic        dev_req_wen;
  logic [31:0] dev_req_addr;
  logic [31:0] dev_req_wdata;
  logic [3:0]  dev_req_wmask;
  logic [31:0] dev_resp_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_errors = 0;

  int          lat;
  int          nbeats;
  int          beat_cyc  [4];
  logic [31:0] beat_addr [4];
  logic [31:0] beat_wdata[4];
  logic [3:0]  beat_wmask[4];
  logic        beat_wen  [4];

  device_req_bridge dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wen        (req_wen),
    .req_addr       (req_addr),
    .req_size       (req_size),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .dev_req_valid  (dev_req_valid),
    .dev_req_wen    (dev_req_wen),
    .dev_req_addr   (dev_req_addr),
    .dev_req_wdata  (dev_req_wdata),
    .dev_req_wmask  (dev_req_wmask),
    .dev_resp_rdata (dev_resp_rdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Helper model: answers a beat in the following cycle, junk otherwise.
  always @(posedge clk) begin
    logic        seen;
    logic [31:0] a;
    seen = dev_req_valid;
    a    = dev_req_addr;
    #1;
    if (!seen)                    dev_resp_rdata = 32'hDEAD_BEEF;
    else if (a == 32'h4060_0000)  dev_resp_rdata = 32'h1111_1111;
    else if (a == 32'h4060_0004)  dev_resp_rdata = 32'h2222_2222;
    else                          dev_resp_rdata = 32'h5A5A_0000;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the bridge idle; returns at the negedge where
  // resp_valid is first seen (resp_ready kept low).
  task automatic run_req(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                         input logic [63:0] wdata, input logic [7:0] wmask);
    check("req_ready_before", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
    req_wmask = wmask;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat    = -1;
    nbeats = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (dev_req_valid && nbeats < 4) begin
        beat_cyc[nbeats]   = k;
        beat_addr[nbeats]  = dev_req_addr;
        beat_wdata[nbeats] = dev_req_wdata;
        beat_wmask[nbeats] = dev_req_wmask;
        beat_wen[nbeats]   = dev_req_wen;
        nbeats++;
      end
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check("resp_timeout", 64'd0, 64'd1);
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_after_hs", {63'd0, resp_valid}, 64'd0);
    check("req_ready_after_hs", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    req_wdata = '0;
    req_wmask = '0;
    resp_ready = 1'b0;
    dev_resp_rdata = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_outputs", {60'd0, dev_req_valid, resp_valid, resp_err, dev_req_wen}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", {63'd0, req_ready}, 64'd1);
    check("idle_dev_outputs", {dev_req_addr, dev_req_wdata}, 64'd0);

    // 8-byte read: two consecutive beats, latency 4
    run_req(1'b0, 32'h4060_0000, 2'd3, 64'd0, 8'h00);
    check("rd8_lat", lat, 4);
    check("rd8_nbeats", nbeats, 2);
    check("rd8_beat0", {beat_cyc[0], beat_addr[0]}, {32'd1, 32'h4060_0000});
    check("rd8_beat1", {beat_cyc[1], beat_addr[1]}, {32'd2, 32'h4060_0004});
    check("rd8_beat_mask", {beat_wen[0], beat_wmask[0], beat_wen[1], beat_wmask[1]}, 64'd0);
    check("rd8_rdata", resp_rdata, 64'h2222_2222_1111_1111);
    check("rd8_err", {63'd0, resp_err}, 64'd0);
    finish_resp();

    // High-word write, single beat
    run_req(1'b1, 32'h4060_0004, 2'd0, 64'hAABB_CCDD_0000_0000, 8'hF0);
    check("wrhi_lat", lat, 3);
    check("wrhi_nbeats", nbeats, 1);
    check("wrhi_beat", {beat_addr[0], beat_wdata[0]}, 64'h4060_0004_AABB_CCDD);
    check("wrhi_mask", {59'd0, beat_wen[0], beat_wmask[0]}, 64'h1F);
    check("wrhi_rdata", resp_rdata, 64'd0);
    finish_resp();

    // Zero-mask write: no beats
    run_req(1'b1, 32'h4060_0000, 2'd0, 64'h1234_5678_9ABC_DEF0, 8'h00);
    check("wr0_lat", lat, 1);
    check("wr0_nbeats", nbeats, 0);
    check("wr0_rdata", resp_rdata, 64'd0);
    finish_resp();

    // Low-word write
    run_req(1'b1, 32'h4060_0008, 2'd0, 64'h1234_5678_9ABC_DEF0, 8'h0F);
    check("wrlo_lat", lat, 3);
    check("wrlo_beat", {beat_addr[0], beat_wdata[0]}, 64'h4060_0008_9ABC_DEF0);
    check("wrlo_mask", {59'd0, beat_wen[0], beat_wmask[0]}, 64'h1F);
    finish_resp();

    // 4-byte read of high word
    run_req(1'b0, 32'h4060_0004, 2'd2, 64'd0, 8'h00);
    check("rdhi_lat", lat, 3);
    check("rdhi_beat", {nbeats, beat_addr[0]}, {32'd1, 32'h4060_0004});
    check("rdhi_rdata", resp_rdata, 64'h2222_2222_0000_0000);
    finish_resp();

    // 1-byte read at low word: full word captured, no shifting
    run_req(1'b0, 32'h4060_0001, 2'd0, 64'd0, 8'h00);
    check("rdb_lat", lat, 3);
    check("rdb_beat", {nbeats, beat_addr[0]}, {32'd1, 32'h4060_0000});
    check("rdb_rdata", resp_rdata, 64'h0000_0000_1111_1111);
    finish_resp();

    // Backpressure: hold resp_ready low
    run_req(1'b0, 32'h4060_0000, 2'd3, 64'd0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {resp_valid, req_ready, resp_rdata[61:0]},
            {1'b1, 1'b0, 62'h2222_2222_1111_1111});
    end
    finish_resp();

`ifdef DEVICE_BRIDGE_RANGE_CHECK_EN
    run_req(1'b0, 32'h8000_0000, 2'd3, 64'd0, 8'h00);
    check("oor_lat", lat, 1);
    check("oor_nbeats", nbeats, 0);
    check("oor_err", {63'd0, resp_err}, 64'd1);
    check("oor_rdata", resp_rdata, 64'd0);
    finish_resp();
`endif

    // Asynchronous reset during BEAT_HI
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 32'h4060_0000;
    req_size  = 2'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_beat_hi", {31'd0, dev_req_valid, dev_req_addr}, {32'd1, 32'h4060_0004});
    reset_n = 1'b0;
    #1;
    check("mid_rst_outs", {dev_req_valid, req_ready, resp_valid, resp_err, 28'd0, dev_req_addr},
          64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {63'd0, req_ready}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {62'd0, resp_valid, dev_req_valid}, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
